// File: rtl/regfile_pkg.sv
// Default sizing constants and the scoreboard counter type shared by the
// register file and its per-register pending counters.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int REG_DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF     = 2;
  localparam int DBG_REG_DEF    = 10;
  localparam int CNT_W_DEF      = 2;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/regfile_sb_cnt.sv
// Pending-write counter for one register: issue increments, writeback
// decrements, a simultaneous pair cancels, and it never wraps in either direction.
module regfile_sb_cnt
  import regfile_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_max,
  output logic             underflow
);

  assign at_max    = &count;
  assign underflow = dec && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through forwarding and a per-register scoreboard
// that tracks outstanding writes reserved at issue time.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int REG_DEPTH  = REG_DEPTH_DEF,
  parameter int NUM_RD     = NUM_RD_DEF,
  parameter int DBG_REG    = DBG_REG_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]                   rd_busy,
  input  logic                                we,
  input  logic [ADDR_WIDTH-1:0]               wa,
  input  logic [DATA_WIDTH-1:0]               wd,
  input  logic                                iss_valid,
  input  logic [ADDR_WIDTH-1:0]               iss_rd,
  output logic                                iss_ready,
  output logic [DATA_WIDTH-1:0]               dbg_data,
  output logic                                err
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(REG_DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  logic [DATA_WIDTH-1:0] regs [REG_DEPTH];
  logic [CNT_W-1:0]      cnt  [REG_DEPTH];
  logic [REG_DEPTH-1:0]  at_max;
  logic [REG_DEPTH-1:0]  unflw;
  logic                  wb_ok;
  logic                  iss_hit;
  logic                  iss_acc;
  logic                  bad_addr;

  assign wb_ok    = we && (wa != '0) && in_range(wa);
  assign iss_hit  = iss_valid && (iss_rd != '0) && in_range(iss_rd);
  assign bad_addr = (we && !in_range(wa)) || (iss_valid && !in_range(iss_rd));

  // A full counter still accepts an issue when a writeback frees a slot this cycle.
  assign iss_ready = !(iss_hit && at_max[iss_rd] && !(wb_ok && (wa == iss_rd)));
  assign iss_acc   = iss_hit && iss_ready;

  assign cnt[0]    = '0;
  assign at_max[0] = 1'b0;
  assign unflw[0]  = 1'b0;

  for (genvar r = 1; r < REG_DEPTH; r++) begin : g_cnt
    regfile_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (iss_acc && (iss_rd == ADDR_WIDTH'(r))),
      .dec       (wb_ok && (wa == ADDR_WIDTH'(r))),
      .count     (cnt[r]),
      .at_max    (at_max[r]),
      .underflow (unflw[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_DEPTH; r++) regs[r] <= '0;
    end else if (wb_ok) begin
      regs[wa] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (bad_addr || (|unflw)) begin
      err <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((rd_addr[i] != '0) && in_range(rd_addr[i])) begin
        if (wb_ok && (wa == rd_addr[i])) begin
          rd_data[i] = wd;
          rd_busy[i] = cnt[rd_addr[i]] > CNT_W'(1);
        end else begin
          rd_data[i] = regs[rd_addr[i]];
          rd_busy[i] = cnt[rd_addr[i]] != '0;
        end
      end
    end
  end

  assign dbg_data = regs[DBG_REG];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: forwarding, x0 behaviour, scoreboard
// saturation, underflow error and asynchronous reset.
module tb_regfile_sb;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_busy;
  logic             we;
  logic [4:0]       wa;
  logic [31:0]      wd;
  logic             iss_valid;
  logic [4:0]       iss_rd;
  logic             iss_ready;
  logic [31:0]      dbg_data;
  logic             err;

  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .dbg_data  (dbg_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we        = 1'b0;
    wa        = '0;
    wd        = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    #3;
    chk("rst_rd0",   rd_data[0], 32'h0);
    chk("rst_busy",  {30'b0, rd_busy}, 32'h0);
    chk("rst_dbg",   dbg_data, 32'h0);
    chk("rst_err",   {31'b0, err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // reserve x5, then write it with same-cycle forwarding on port 1
    iss_valid = 1'b1; iss_rd = 5'd5;
    #2 chk("x5_iss_ready", {31'b0, iss_ready}, 32'h1);
    tick();
    idle();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    rd_addr[0] = 5'd0; rd_addr[1] = 5'd5;
    #2;
    chk("x5_fwd",      rd_data[1], 32'hDEADBEEF);
    chk("x5_fwd_busy", {31'b0, rd_busy[1]}, 32'h0);
    tick();
    idle();
    rd_addr[0] = 5'd5;
    #2;
    chk("x5_read", rd_data[0], 32'hDEADBEEF);
    chk("x5_err",  {31'b0, err}, 32'h0);

    // x0 ignores writes and is never reserved
    we = 1'b1; wa = 5'd0; wd = 32'h1234;
    tick();
    idle();
    rd_addr[0] = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #2;
    chk("x0_read",  rd_data[0], 32'h0);
    chk("x0_ready", {31'b0, iss_ready}, 32'h1);
    tick();
    idle();
    #2;
    chk("x0_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("x0_err",  {31'b0, err}, 32'h0);

    // x7 saturation
    rd_addr[0] = 5'd7;
    for (int k = 0; k < 3; k++) begin
      iss_valid = 1'b1; iss_rd = 5'd7;
      #2 chk($sformatf("x7_iss%0d", k), {31'b0, iss_ready}, 32'h1);
      tick();
    end
    #2;
    chk("x7_busy3",  {31'b0, rd_busy[0]}, 32'h1);
    chk("x7_full",   {31'b0, iss_ready}, 32'h0);
    tick();
    we = 1'b1; wa = 5'd7; wd = 32'h77;
    #2;
    chk("x7_pair_ready", {31'b0, iss_ready}, 32'h1);
    chk("x7_pair_busy",  {31'b0, rd_busy[0]}, 32'h1);
    tick();
    we = 1'b0;
    #2 chk("x7_still_full", {31'b0, iss_ready}, 32'h0);
    idle();
    we = 1'b1; wa = 5'd7; wd = 32'h71;
    tick();
    wd = 32'h72;
    tick();
    wd = 32'h73;
    #2 chk("x7_last_wb_busy", {31'b0, rd_busy[0]}, 32'h0);
    tick();
    idle();
    #2;
    chk("x7_data",    rd_data[0], 32'h73);
    chk("x7_drained", {31'b0, rd_busy[0]}, 32'h0);
    chk("x7_err",     {31'b0, err}, 32'h0);

    // x3: single reservation retired by writeback
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    idle();
    rd_addr[0] = 5'd3;
    #2 chk("x3_busy_pre", {31'b0, rd_busy[0]}, 32'h1);
    we = 1'b1; wa = 5'd3; wd = 32'h55;
    #2;
    chk("x3_wb_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("x3_wb_data", rd_data[0], 32'h55);
    tick();
    idle();
    #2;
    chk("x3_post_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("x3_post_err",  {31'b0, err}, 32'h0);

    // x9 writeback with nothing outstanding
    we = 1'b1; wa = 5'd9; wd = 32'h99;
    #2 chk("x9_err_pre", {31'b0, err}, 32'h0);
    tick();
    idle();
    rd_addr[0] = 5'd9;
    #2;
    chk("x9_err",  {31'b0, err}, 32'h1);
    chk("x9_data", rd_data[0], 32'h99);
    tick();
    tick();
    chk("x9_err_sticky", {31'b0, err}, 32'h1);

    // load x10, reserve x4, then asynchronous reset mid-cycle
    we = 1'b1; wa = 5'd10; wd = 32'hA5;
    tick();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    rd_addr[0] = 5'd4; rd_addr[1] = 5'd10;
    #1;
    chk("pre_rst_dbg",  dbg_data, 32'hA5);
    chk("pre_rst_busy", {31'b0, rd_busy[0]}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dbg",  dbg_data, 32'h0);
    chk("arst_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("arst_err",  {31'b0, err}, 32'h0);
    chk("arst_rd10", rd_data[1], 32'h0);
    #1 rst_n = 1'b1;
    tick();
    #1 chk("post_rst_busy", {31'b0, rd_busy[0]}, 32'h0);
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    #1;
    chk("post_rst_iss_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("post_rst_err",      {31'b0, err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
